// File: rtl/found_reporter_pkg.sv
// Shared types and helpers for the found reporter.
// FOUND_REPORTER_PARITY_EN adds an even-parity bit to every UART frame.
package found_reporter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_LOAD,
    ST_START,
    ST_DATA,
`ifdef FOUND_REPORTER_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_DONE
  } state_e;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam int MSG_BYTES = 11;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) begin
      c = 8'h30 + {4'h0, nib};
    end else begin
      c = 8'h37 + {4'h0, nib};
    end
    return c;
  endfunction

  // Scans downwards so the lowest set index is the one that survives.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/found_reporter_if.sv
// Bus between the pipeline driver and the found reporter.
interface found_reporter_if #(parameter int NUM_LANES = 10);
  logic [28:0]          count;
  logic [NUM_LANES-1:0] found;
  logic                 tx;
  logic                 busy;
  logic                 reported;
  logic [32:0]          candidate;

  modport master (output count, output found,
                  input tx, input busy, input reported, input candidate);
  modport slave  (input count, input found,
                  output tx, output busy, output reported, output candidate);
endinterface

// File: rtl/found_reporter_uart_tx_byte.sv
// One-byte UART transmitter with start/ready handshake; tx is registered.
// FOUND_REPORTER_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_byte
  import found_reporter_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       tx
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

  state_e           phase_q, phase_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             baud_last_s;
  logic             done_s;

  // Bit sequencing; tx_d reflects the current phase so the line lags it by one register.
  always_comb begin
    phase_d     = phase_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tx_d        = 1'b1;
    done_s      = 1'b0;
    baud_last_s = (baud_q == BAUD_LAST);
    case (phase_q)
      ST_IDLE: begin
        if (start) begin
          phase_d = ST_START;
          baud_d  = {CNT_W{1'b0}};
          bit_d   = 3'd0;
          shift_d = data;
          par_d   = even_parity(data);
        end else begin
          phase_d = ST_IDLE;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (baud_last_s) begin
          phase_d = ST_DATA;
          baud_d  = {CNT_W{1'b0}};
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (baud_last_s) begin
          baud_d  = {CNT_W{1'b0}};
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef FOUND_REPORTER_PARITY_EN
            phase_d = ST_PARITY;
`else
            phase_d = ST_STOP;
`endif
          end else begin
            phase_d = ST_DATA;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`ifdef FOUND_REPORTER_PARITY_EN
      ST_PARITY: begin
        tx_d = par_q;
        if (baud_last_s) begin
          phase_d = ST_STOP;
          baud_d  = {CNT_W{1'b0}};
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_last_s) begin
          phase_d = ST_IDLE;
          baud_d  = {CNT_W{1'b0}};
          done_s  = 1'b1;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        phase_d = ST_IDLE;
      end
    endcase
  end

  // Frame state registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      phase_q <= ST_IDLE;
      baud_q  <= {CNT_W{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign ready = (phase_q == ST_IDLE);
  assign done  = done_s;
  assign tx    = tx_q;

endmodule

// File: rtl/found_reporter.sv
// Latches the first pipeline match and sends it as "XXXXXXXXX\r\n" over UART.
// FOUND_REPORTER_PARITY_EN selects 8E1 frames instead of 8N1.
module found_reporter
  import found_reporter_pkg::*;
#(
  parameter int CLK_HZ       = 100000000,
  parameter int BAUD         = 115200,
  parameter int PIPE_LATENCY = 64,
  parameter int NUM_LANES    = 10
) (
  input  logic             CLK,
  input  logic             reset,
  found_reporter_if.slave  bus
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;

  state_e        state_q, state_d;
  logic [28:0]   cnt_q, cnt_d;
  logic [3:0]    lane_q, lane_d;
  logic [32:0]   candidate_q, candidate_d;
  logic [3:0]    idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          reported_q, reported_d;

  logic [NUM_LANES-1:0] found_s;
  logic [15:0]          found_ext_s;
  logic [35:0]          cand36_s;
  logic [3:0]           nib_s;
  logic [7:0]           msg_byte_s;
  logic                 start_s;
  logic                 ready_s;
  logic                 done_s;
  logic                 tx_s;

  assign found_s     = bus.found;
  assign found_ext_s = 16'(found_s);
  assign cand36_s    = {3'b000, candidate_q};

  // Message byte: nine hex digits MSB first, then CR LF.
  always_comb begin
    nib_s      = 4'(cand36_s >> (6'd32 - {idx_q, 2'b00}));
    msg_byte_s = 8'h00;
    if (idx_q < 4'd9) begin
      msg_byte_s = hex_ascii(nib_s);
    end else if (idx_q == 4'd9) begin
      msg_byte_s = CR;
    end else begin
      msg_byte_s = LF;
    end
  end

  // Top-level sequencer: capture once, then feed MSG_BYTES bytes to the UART.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    candidate_d = candidate_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    reported_d  = reported_q;
    start_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found_ext_s != 16'h0000) begin
          state_d = ST_CAPTURE;
          cnt_d   = bus.count;
          lane_d  = lowest_set(found_ext_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        // Subtraction wraps modulo 2^29 by construction of the 29-bit field.
        candidate_d = {cnt_q - 29'(PIPE_LATENCY), lane_q};
        busy_d      = 1'b1;
        idx_d       = 4'd0;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        start_s = 1'b1;
        if (ready_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_START: begin
        if (done_s) begin
          if (idx_q == 4'(MSG_BYTES - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DONE: begin
        busy_d     = 1'b0;
        reported_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 29'd0;
      lane_q      <= 4'd0;
      candidate_q <= 33'd0;
      idx_q       <= 4'd0;
      busy_q      <= 1'b0;
      reported_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      candidate_q <= candidate_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      reported_q  <= reported_d;
    end
  end

  uart_tx_byte #(.DIV(DIV)) u_tx (
    .CLK   (CLK),
    .reset (reset),
    .start (start_s),
    .data  (msg_byte_s),
    .ready (ready_s),
    .done  (done_s),
    .tx    (tx_s)
  );

  assign bus.tx        = tx_s;
  assign bus.busy      = busy_q;
  assign bus.reported  = reported_q;
  assign bus.candidate = candidate_q;

endmodule

// File: tb/tb_found_reporter.sv
// Directed self-checking bench for found_reporter (DIV = 10).
module tb_found_reporter;

  localparam int CLK_HZ    = 1000000;
  localparam int BAUD      = 100000;
  localparam int DIV       = 10;
  localparam int NUM_LANES = 10;
`ifdef FOUND_REPORTER_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int LINE_CYC = 11 * (DIV * FBITS + 1) + 2;

  logic CLK = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  found_reporter_if #(.NUM_LANES(NUM_LANES)) bus ();

  found_reporter #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .PIPE_LATENCY(64), .NUM_LANES(NUM_LANES)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receive one frame, starting at a negedge; err counts timeout/framing/parity problems.
  task automatic recv_byte(output logic [7:0] b, output int err);
    int w;
    err = 0;
    b   = 8'h00;
    w   = 0;
    while (bus.tx !== 1'b0 && w < 3000) begin
      @(negedge CLK);
      w++;
    end
    if (bus.tx !== 1'b0) begin
      err = 1;
    end else begin
      repeat (DIV / 2 - 1) @(negedge CLK);
      if (bus.tx !== 1'b0) err++;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge CLK);
        b[i] = bus.tx;
      end
`ifdef FOUND_REPORTER_PARITY_EN
      repeat (DIV) @(negedge CLK);
      if (bus.tx !== ^b) err++;
`endif
      repeat (DIV) @(negedge CLK);
      if (bus.tx !== 1'b1) err++;
    end
  endtask

  task automatic recv_line(input int n, output logic [87:0] got, output int errs);
    logic [7:0] b;
    int e;
    got  = 88'h0;
    errs = 0;
    for (int k = 0; k < n; k++) begin
      recv_byte(b, e);
      got  = {got[79:0], b};
      errs = errs + e;
    end
  endtask

  task automatic wait_idle(output int waited);
    waited = 0;
    while (bus.busy !== 1'b0 && waited < 3000) begin
      @(negedge CLK);
      waited++;
    end
  endtask

  task automatic pulse_found(input logic [28:0] c, input logic [NUM_LANES-1:0] f);
    bus.count = c;
    bus.found = f;
    @(posedge CLK);
    @(negedge CLK);
    bus.found = '0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.found = '0;
    bus.count = 29'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.found = '0;
    bus.count = 29'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (bus.tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", bus.tx); else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++;
    if (bus.reported !== 1'b0) $display("FAIL reset_reported: got %b want 0", bus.reported); else n_pass++;
    n_checks++;
    if (bus.candidate !== 33'h0) $display("FAIL reset_candidate: got %h want 0", bus.candidate); else n_pass++;
    reset = 1'b0;
    repeat (5) @(negedge CLK);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1)
      $display("FAIL idle_quiet: got busy=%b tx=%b want busy=0 tx=1", bus.busy, bus.tx);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [87:0] got;
    logic [87:0] exp;
    int errs, c0, w;
    exp = {"000000243", 8'h0D, 8'h0A};
    pulse_found(29'd100, 10'b0000001000);
    c0 = cyc;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy_capture: got %b want 0", bus.busy); else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", bus.busy); else n_pass++;
    n_checks++;
    if (bus.candidate !== 33'h243) $display("FAIL basic_candidate: got %h want 243", bus.candidate); else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (bus.tx !== 1'b1) $display("FAIL basic_tx_before_start: got %b want 1", bus.tx); else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (bus.tx !== 1'b0) $display("FAIL basic_start_edge: got %b want 0", bus.tx); else n_pass++;
    recv_line(11, got, errs);
    n_checks++;
    if (errs !== 0) $display("FAIL basic_framing: got %0d errors want 0", errs); else n_pass++;
    n_checks++;
    if (got !== exp) $display("FAIL basic_line: got %h want %h", got, exp); else n_pass++;
    wait_idle(w);
    n_checks++;
    if (cyc - c0 !== LINE_CYC) $display("FAIL basic_duration: got %0d want %0d", cyc - c0, LINE_CYC); else n_pass++;
    n_checks++;
    if (bus.reported !== 1'b1 || bus.tx !== 1'b1)
      $display("FAIL basic_reported: got reported=%b tx=%b want 1 1", bus.reported, bus.tx);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [87:0] got;
    logic [87:0] exp;
    int errs, w;
    exp = {"1FFFFFCA0", 8'h0D, 8'h0A};
    do_reset();
    pulse_found(29'd10, 10'b0000000001);
    @(negedge CLK);
    n_checks++;
    if (bus.candidate !== 33'h1FFFFFCA0) $display("FAIL wrap_candidate: got %h want 1FFFFFCA0", bus.candidate); else n_pass++;
    recv_line(11, got, errs);
    n_checks++;
    if (errs !== 0 || got !== exp) $display("FAIL wrap_line: got %h (errs %0d) want %h", got, errs, exp); else n_pass++;
    wait_idle(w);
    n_checks++;
    if (bus.reported !== 1'b1) $display("FAIL wrap_reported: got %b want 1", bus.reported); else n_pass++;
  endtask

  task automatic test_priority();
    logic [87:0] g1, g2, got;
    logic [87:0] exp;
    int e1, e2, w, lows;
    exp = {"000000002", 8'h0D, 8'h0A};
    do_reset();
    pulse_found(29'd64, 10'b0000100100);
    @(negedge CLK);
    n_checks++;
    if (bus.candidate !== 33'h002) $display("FAIL prio_candidate: got %h want 002", bus.candidate); else n_pass++;
    recv_line(3, g1, e1);
    pulse_found(29'd500, 10'b0000000001);
    recv_line(8, g2, e2);
    got = {g1[23:0], g2[63:0]};
    n_checks++;
    if (e1 + e2 !== 0 || got !== exp) $display("FAIL prio_line: got %h (errs %0d) want %h", got, e1 + e2, exp); else n_pass++;
    wait_idle(w);
    n_checks++;
    if (bus.candidate !== 33'h002) $display("FAIL prio_mid_ignore: got %h want 002", bus.candidate); else n_pass++;
    pulse_found(29'd777, 10'b1111111111);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) lows++;
    end
    n_checks++;
    if (lows !== 0) $display("FAIL done_ignore_line: got %0d active cycles want 0", lows); else n_pass++;
    n_checks++;
    if (bus.candidate !== 33'h002 || bus.reported !== 1'b1)
      $display("FAIL done_ignore_state: got cand=%h rep=%b want 002 1", bus.candidate, bus.reported);
    else n_pass++;
  endtask

  task automatic test_reset_mid_bit();
    logic [87:0] got;
    logic [87:0] exp;
    int errs, w;
    exp = {"000000889", 8'h0D, 8'h0A};
    do_reset();
    pulse_found(29'd100, 10'b0000001000);
    recv_line(3, got, errs);
    w = 0;
    while (bus.tx !== 1'b0 && w < 500) begin
      @(negedge CLK);
      w++;
    end
    repeat (25) @(negedge CLK);
    n_checks++;
    if (bus.tx !== 1'b0) $display("FAIL midbit_precondition: got %b want 0", bus.tx); else n_pass++;
    reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.reported !== 1'b0 || bus.candidate !== 33'h0)
      $display("FAIL midbit_reset: got tx=%b busy=%b rep=%b cand=%h want 1 0 0 0",
               bus.tx, bus.busy, bus.reported, bus.candidate);
    else n_pass++;
    reset = 1'b0;
    @(negedge CLK);
    pulse_found(29'd200, 10'b1000000000);
    @(negedge CLK);
    n_checks++;
    if (bus.candidate !== 33'h889) $display("FAIL rerun_candidate: got %h want 889", bus.candidate); else n_pass++;
    recv_line(11, got, errs);
    n_checks++;
    if (errs !== 0 || got !== exp) $display("FAIL rerun_line: got %h (errs %0d) want %h", got, errs, exp); else n_pass++;
    wait_idle(w);
    n_checks++;
    if (bus.reported !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL rerun_reported: got rep=%b busy=%b want 1 0", bus.reported, bus.busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_priority();
    test_reset_mid_bit();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
